// File: rtl/fifo_thresh.sv
// fifo_thresh: synchronous FIFO with programmable almost-empty/almost-full thresholds and sticky error
module fifo_thresh #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4,
  parameter int THR_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic [THR_WIDTH-1:0]  thr_low,
  input  logic [THR_WIDTH-1:0]  thr_high,
  output logic [THR_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  error
);
  localparam logic [THR_WIDTH-1:0] DEPTH = THR_WIDTH'(2 ** ADDR_WIDTH);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc, fault;
  assign empty        = count == '0;
  assign full         = count == DEPTH;
  assign almost_empty = count <= thr_low;
  assign almost_full  = count >= thr_high;
  // a read frees a slot in the same edge, so a full FIFO still accepts a paired write
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;
  assign fault  = (wr_en && full && !rd_en) || (rd_en && empty);
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (wr_acc) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      valid_out <= rd_acc;
      count     <= (wr_acc && !rd_acc) ? count + 1'b1 : (rd_acc && !wr_acc) ? count - 1'b1 : count;
      if (fault) error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_thresh.sv
// tb_fifo_thresh: scoreboard bench for fifo_thresh; a queue model predicts occupancy, flags and read data
module tb_fifo_thresh;
  logic clk = 1'b0;
  logic reset, wr_en, rd_en;
  logic [5:0] data_in, data_out;
  logic [4:0] thr_low, thr_high, count;
  logic valid_out, empty, full, almost_empty, almost_full, error;
  int n_vec = 0, n_bad = 0;
  logic [5:0] m_q[$];
  logic [5:0] exp_q[$];
  bit m_err, m_valid;

  fifo_thresh dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .valid_out(valid_out), .thr_low(thr_low), .thr_high(thr_high),
    .count(count), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check("count", count, m_q.size());
    check("empty", empty, m_q.size() == 0);
    check("full", full, m_q.size() == 16);
    check("almost_empty", almost_empty, m_q.size() <= int'(thr_low));
    check("almost_full", almost_full, m_q.size() >= int'(thr_high));
    check("error", error, m_err);
    check("valid_out", valid_out, m_valid);
    if (valid_out === 1'b1) begin
      if (exp_q.size() > 0) check("data_out", data_out, exp_q.pop_front());
      else check("spurious_valid", valid_out, 0);
    end
  endtask

  task automatic cycle(input bit w, input logic [5:0] d, input bit r);
    bit f, e, wa, ra;
    wr_en = w; rd_en = r; data_in = d;
    f = m_q.size() == 16;
    e = m_q.size() == 0;
    wa = w && (!f || r);
    ra = r && !e;
    if (ra) exp_q.push_back(m_q.pop_front());
    if (wa) m_q.push_back(d);
    if ((w && f && !r) || (r && e)) m_err = 1'b1;
    m_valid = ra;
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset(input bit w, input bit r);
    reset = 1'b0; wr_en = w; rd_en = r; data_in = 6'h3E;
    m_q.delete(); exp_q.delete(); m_err = 1'b0; m_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    check_state();
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    thr_low = 5'd2; thr_high = 5'd14;
    do_reset(1'b0, 1'b0);
    do_reset(1'b0, 1'b0);
    cycle(0, 0, 0);
    // fill and drain in order
    for (int i = 1; i <= 16; i++) cycle(1, 6'(i), 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1);
    cycle(0, 0, 0);
    // full with paired read/write, pointers wrap
    for (int i = 0; i < 16; i++) cycle(1, 6'(i + 32), 0);
    cycle(1, 6'h15, 1);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1);
    cycle(0, 0, 0);
    // overflow drops data and sets error
    for (int i = 0; i < 16; i++) cycle(1, 6'(i + 16), 0);
    cycle(1, 6'h3F, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1);
    cycle(0, 0, 0);
    // underflow with simultaneous write
    do_reset(1'b0, 1'b0);
    cycle(1, 6'h2A, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    // threshold boundaries
    for (int i = 0; i < 3; i++) cycle(1, 6'(i + 5), 0);
    thr_low = 5'd0; thr_high = 5'd0;
    cycle(0, 0, 0);
    thr_low = 5'd16; thr_high = 5'd17;
    cycle(0, 0, 0);
    thr_low = 5'd31; thr_high = 5'd3;
    cycle(0, 0, 0);
    thr_low = 5'd3; thr_high = 5'd16;
    cycle(0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1);
    thr_low = 5'd0; thr_high = 5'd0;
    cycle(0, 0, 0);
    thr_low = 5'd2; thr_high = 5'd14;
    // reset mid-operation: count 7, error set
    do_reset(1'b0, 1'b0);
    cycle(1, 6'h01, 1);
    for (int i = 0; i < 6; i++) cycle(1, 6'(i + 2), 0);
    do_reset(1'b1, 1'b1);
    cycle(1, 6'h11, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    check("scoreboard_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end
endmodule
